// File: rtl/perf_monitor_mc.sv
// Multi-channel performance monitor: counts cycles, retired instructions and
// generic events inside a start/stop window, then derives fixed-point CPI.
module perf_monitor_mc #(
    parameter int CNT_W  = 32,
    parameter int N_EVT  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_instr,
    input  logic                     end_instr,
    input  logic                     instr_retire,
    input  logic [N_EVT-1:0]         evt,
    output logic [CNT_W-1:0]         total_cycles,
    output logic [CNT_W-1:0]         instr_count,
    output logic [N_EVT*CNT_W-1:0]   evt_count,
    output logic [CNT_W-1:0]         cpi,
    output logic                     cpi_valid,
    output logic                     running,
    output logic                     busy,
    output logic                     div_zero,
    output logic [N_EVT+1:0]         ovf
);

    localparam int W    = CNT_W + FRAC_W;
    localparam int IT_W = $clog2(W + 1);
    localparam logic [IT_W-1:0] ITER_DONE = IT_W'(W);

    typedef enum logic [1:0] {IDLE, COUNT, DIV, DONE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   total_reg;
    logic [CNT_W-1:0]   instr_reg;
    logic [CNT_W-1:0]   cpi_reg;
    logic [N_EVT+1:0]   ovf_reg;
    logic               cpi_valid_reg;
    logic               div_zero_reg;
    logic [W-1:0]       num_reg;
    logic [W-1:0]       quo_reg;
    logic [CNT_W:0]     rem_reg;
    logic [IT_W-1:0]    iter_reg;

    logic               counting;
    logic [CNT_W-1:0]   total_next;
    logic [CNT_W-1:0]   instr_next;
    logic [N_EVT-1:0]   evt_ovf_set;
    logic [CNT_W+1:0]   trial;
    logic [CNT_W+1:0]   diff;
    logic               fits;

    assign counting = (state_reg == COUNT);

    // Saturating increments: an all-ones counter holds its value.
    assign total_next = (&total_reg) ? total_reg : total_reg + CNT_W'(1);
    assign instr_next = (instr_retire && !(&instr_reg)) ? instr_reg + CNT_W'(1) : instr_reg;

    // One restoring step: the borrow out of the trial subtraction decides the bit.
    assign trial = {rem_reg, num_reg[W-1]};
    assign diff  = trial - {2'b00, instr_reg};
    assign fits  = ~diff[CNT_W+1];

    genvar gi;
    generate
        for (gi = 0; gi < N_EVT; gi++) begin : g_evt
            logic [CNT_W-1:0] cnt_reg;

            assign evt_ovf_set[gi]              = counting && evt[gi] && (&cnt_reg);
            assign evt_count[gi*CNT_W +: CNT_W] = cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (start_instr) begin
                    cnt_reg <= '0;
                end else if (counting && evt[gi] && !(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            total_reg     <= '0;
            instr_reg     <= '0;
            cpi_reg       <= '0;
            ovf_reg       <= '0;
            cpi_valid_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
            num_reg       <= '0;
            quo_reg       <= '0;
            rem_reg       <= '0;
            iter_reg      <= '0;
        end else if (start_instr) begin
            state_reg     <= COUNT;
            total_reg     <= '0;
            instr_reg     <= '0;
            cpi_reg       <= '0;
            ovf_reg       <= '0;
            cpi_valid_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                COUNT: begin
                    total_reg <= total_next;
                    instr_reg <= instr_next;
                    ovf_reg   <= ovf_reg | {evt_ovf_set,
                                            instr_retire & (&instr_reg),
                                            &total_reg};
                    if (end_instr) begin
                        if (instr_next == '0) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= DIV;
                            num_reg   <= {total_next, {FRAC_W{1'b0}}};
                            quo_reg   <= '0;
                            rem_reg   <= '0;
                            iter_reg  <= '0;
                        end
                    end
                end
                DIV: begin
                    if (iter_reg != ITER_DONE) begin
                        rem_reg  <= fits ? diff[CNT_W:0] : trial[CNT_W:0];
                        num_reg  <= {num_reg[W-2:0], 1'b0};
                        quo_reg  <= {quo_reg[W-2:0], fits};
                        iter_reg <= iter_reg + IT_W'(1);
                    end else begin
                        cpi_reg       <= (|quo_reg[W-1:CNT_W]) ? '1 : quo_reg[CNT_W-1:0];
                        cpi_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // Only the zero-divisor path arrives here without a result.
                    if (!cpi_valid_reg) begin
                        cpi_reg       <= '1;
                        div_zero_reg  <= 1'b1;
                        cpi_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign total_cycles = total_reg;
    assign instr_count  = instr_reg;
    assign cpi          = cpi_reg;
    assign cpi_valid    = cpi_valid_reg;
    assign div_zero     = div_zero_reg;
    assign ovf          = ovf_reg;
    assign running      = (state_reg == COUNT);
    assign busy         = (state_reg == DIV);

endmodule

// File: doc/perf_monitor_mc.md
# perf_monitor_mc

Parametrised multi-channel performance monitor for the SIMD AES processor. It counts elapsed cycles, retired instructions and N_EVT generic event lines inside a start/stop measurement window. At window close it computes fixed-point CPI with an iterative restoring divider. It sits beside the core, which drives its start/stop and retire strobes, and feeds the simulation benches and the debug readout.

## Interface
- CNT_W, 32, width of every counter and of cpi
- N_EVT, 4, number of generic event channels (1..16)
- FRAC_W, 8, fractional bits of cpi (unsigned Q(CNT_W-FRAC_W).FRAC_W)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_instr  in  1  pulse; opens a window (clears counters)
- end_instr  in  1  pulse; closes the window, launches CPI computation
- instr_retire  in  1  one instruction retired this cycle
- evt  in  N_EVT  per-channel event strobes, one count per cycle high
- total_cycles  out  CNT_W  cycles in window
- instr_count  out  CNT_W  retired instructions in window
- evt_count  out  N_EVT*CNT_W  channel i in bits [i*CNT_W +: CNT_W]
- cpi  out  CNT_W  total_cycles/instr_count, FRAC_W fraction bits
- cpi_valid  out  1  cpi holds the result for the last closed window
- running  out  1  state is COUNT
- busy  out  1  state is DIV
- div_zero  out  1  last window had instr_count == 0
- ovf  out  N_EVT+2  sticky saturation flags: bit0 cycles, bit1 instr, bit2+i evt i

## Operation
- States: IDLE, COUNT, DIV, DONE. Reset -> IDLE, with every output 0.
- start_instr has absolute priority in every state. On that edge all counters, ovf, cpi, cpi_valid and div_zero are cleared to 0. Next state COUNT. A start during DIV aborts the division.
- COUNT: each edge increments total_cycles. instr_count increments if instr_retire. evt_count[i] increments if evt[i].
- The edge that samples end_instr (without start_instr) still counts, then the counters freeze. Next state is DIV, or DONE if instr_count (including that edge's increment) is 0.
- end_instr outside COUNT is ignored. instr_retire and evt are ignored outside COUNT.
- Saturation: a counter at all-ones stays all-ones and sets its ovf bit. The bit is cleared only by start_instr or reset.
- DIV: restoring divide with W = CNT_W+FRAC_W iterations. Numerator is {total_cycles, FRAC_W zeros}. Divisor is instr_count. One quotient bit per edge, MSB first. Remainder register is CNT_W+1 bits.
- Result: if quotient bits [W-1:CNT_W] are nonzero, cpi = all-ones. Otherwise cpi = quotient[CNT_W-1:0]. The result truncates, no rounding.
- Zero divisor: cpi = all-ones and div_zero = 1. The DIV state is skipped.
- DONE: cpi_valid = 1. Counters and cpi hold until the next start_instr.
- Counters are readable at all times. Their values in COUNT are live.

## Timing
- Start sampled at edge k and end sampled at edge k+N, with no saturation: total_cycles = N, counting edges k+1..k+N.
- running is high after edge k through edge k+N, and low after edge k+N.
- DIV occupies edges k+N+1 .. k+N+W, with busy high over that span. State becomes DONE at edge k+N+W+1. cpi and cpi_valid become visible after that edge: W+1 cycles after end. With defaults that is 41 cycles.
- Zero-instruction window: DONE, cpi_valid and div_zero all visible after edge k+N+1.
- Simultaneous start_instr and end_instr: treated as start only.
- Reset asserted mid-window or mid-DIV returns immediately to IDLE with all outputs 0. No partial result survives.

## Test plan
- Defaults. Start, 100 cycles with 40 retire pulses, end on the 100th cycle. Required: total_cycles=100, instr_count=40, cpi=640 (0x280, CPI 2.5), cpi_valid rises exactly 41 cycles after the end edge, div_zero=0.
- Window of 7 cycles with no retire pulses. Required: cpi=0xFFFFFFFF, div_zero=1, cpi_valid one cycle after end, busy never high.
- CNT_W=8, FRAC_W=4. 300 cycles with 2 retire pulses. Required: total_cycles=255, ovf[0]=1, ovf[1]=0, cpi=0xFF (true quotient 127.5 saturates).
- evt[0] high every cycle and evt[2] high on alternate cycles over a 50-cycle window. Required: evt_count[0]=50, evt_count[2]=25, others 0. Pulses before start and after end are not counted.
- start_instr 10 cycles into DIV. Required: busy drops, counters=0, cpi_valid=0, running=1. A second window of 20 cycles and 5 instr gives cpi=1024.
- rst_n low mid-COUNT and again mid-DIV. Required: all outputs 0 asynchronously. end_instr after reset is ignored and the state stays IDLE.
